// File: rtl/seg_pkg.sv
// Shared types and hex font for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a} and active-low.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: digit i blanks when every nibble at or above it is zero.
// Digit 0 never blanks, so an all-zero word still shows one "0".
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] snap,
  input  logic                  lz_blank,
  output logic [N_DIGITS-1:0]   blank
);

  logic zero_run_s;

  // Walk down from the most significant nibble while the run of zeros lasts.
  always_comb begin
    zero_run_s = 1'b1;
    blank      = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (snap[4*i +: 4] == 4'h0);
      blank[i]   = lz_blank & zero_run_s;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-channel seven-segment scan driver: per-frame snapshot of the selected channel,
// time-multiplexed active-low anodes with guard interval, PWM brightness and freeze.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int N_CH     = 4,
  parameter int DIV_LOG2 = 18,
  parameter int BRIGHT_W = 3,
  parameter int GUARD    = 4
) (
  input  logic                       CLK100MHZ,
  input  logic                       reset_n,
  input  logic [N_CH*4*N_DIGITS-1:0] ch_data,
  input  logic [$clog2(N_CH)-1:0]    ch_sel,
  input  logic                       freeze,
  input  logic                       lz_blank,
  input  logic [N_DIGITS-1:0]        dp,
  input  logic [BRIGHT_W-1:0]        bright,
  output logic [6:0]                 seg,
  output logic                       dp_n,
  output logic [N_DIGITS-1:0]        an,
  output logic                       frame_tick
);

  localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int WORD_W = 4 * N_DIGITS;
  localparam int SEL_W  = $clog2(N_CH);

  logic [DIV_LOG2-1:0] pcnt_r;
  logic [DIG_W-1:0]    dig_r;
  logic [WORD_W-1:0]   snap_r;
  logic [N_DIGITS-1:0] dp_snap_r;
  logic [WORD_W-1:0]   sel_word_s;
  logic [N_DIGITS-1:0] blank_s;
  logic                slot_end_s;
  logic                frame_start_s;
  logic                on_s;
  logic                show_s;
  logic [3:0]          nib_s;

  // Channel select; out-of-range indices fall back to channel 0.
  always_comb begin
    sel_word_s = ch_data[WORD_W-1:0];
    for (int k = 1; k < N_CH; k++) begin
      sel_word_s = (ch_sel == SEL_W'(k)) ? ch_data[k*WORD_W +: WORD_W] : sel_word_s;
    end
  end

  // Slot/frame boundaries, PWM window and the nibble of the digit being scanned.
  always_comb begin
    slot_end_s    = (pcnt_r == {DIV_LOG2{1'b1}});
    frame_start_s = slot_end_s && (dig_r == DIG_W'(N_DIGITS - 1));
    on_s          = (pcnt_r >= DIV_LOG2'(GUARD)) &&
                    (pcnt_r[DIV_LOG2-1 -: BRIGHT_W] <= bright);
    nib_s         = snap_r[{dig_r, 2'b00} +: 4];
    show_s        = on_s && !blank_s[dig_r];
  end

  seg_lz_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lz_mask (
    .snap     (snap_r),
    .lz_blank (lz_blank),
    .blank    (blank_s)
  );

  // Slot prescaler and digit counter.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_r <= '0;
      dig_r  <= '0;
    end else begin
      pcnt_r <= pcnt_r + DIV_LOG2'(1);
      if (slot_end_s) begin
        if (dig_r == DIG_W'(N_DIGITS - 1)) begin
          dig_r <= '0;
        end else begin
          dig_r <= dig_r + DIG_W'(1);
        end
      end
    end
  end

  // Frame snapshot: the display only changes at frame boundaries so it never tears.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      snap_r     <= '0;
      dp_snap_r  <= '0;
      frame_tick <= 1'b0;
    end else if (frame_start_s && !freeze) begin
      snap_r     <= sel_word_s;
      dp_snap_r  <= dp;
      frame_tick <= 1'b1;
    end else begin
      frame_tick <= 1'b0;
    end
  end

  // Registered display drive; blanked digits keep scanning their anode.
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      an   <= '1;
      seg  <= SEG_BLANK;
      dp_n <= 1'b1;
    end else begin
      an   <= on_s ? ~(N_DIGITS'(1) << dig_r) : '1;
      seg  <= show_s ? hex2seg(nib_s) : SEG_BLANK;
      dp_n <= show_s ? ~dp_snap_r[dig_r] : 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with a 16-clock slot / 64-clock frame configuration.
module tb_seg_scan_mux;

  localparam int N_DIGITS = 4;
  localparam int N_CH     = 2;
  localparam int DIV_LOG2 = 4;
  localparam int BRIGHT_W = 2;
  localparam int GUARD    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ch_data;
  logic        ch_sel;
  logic        freeze;
  logic        lz_blank;
  logic [3:0]  dp;
  logic [1:0]  bright;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .N_DIGITS (N_DIGITS),
    .N_CH     (N_CH),
    .DIV_LOG2 (DIV_LOG2),
    .BRIGHT_W (BRIGHT_W),
    .GUARD    (GUARD)
  ) dut (
    .CLK100MHZ  (clk),
    .reset_n    (reset_n),
    .ch_data    (ch_data),
    .ch_sel     (ch_sel),
    .freeze     (freeze),
    .lz_blank   (lz_blank),
    .dp         (dp),
    .bright     (bright),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_an"},   {28'd0, an},         32'hF);
    check_val({tag, "_seg"},  {25'd0, seg},        32'h7F);
    check_val({tag, "_dpn"},  {31'd0, dp_n},       32'd1);
    check_val({tag, "_tick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  // Counts clocks until frame_tick is seen (bounded), then checks the count.
  task automatic wait_tick(input string tag, input int exp_n);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = frame_tick;
    end
    check_val(tag, n, exp_n);
  endtask

  task automatic mid_action(input int act);
    case (act)
      1: begin ch_sel = 1'b1; lz_blank = 1'b1; end
      2: begin freeze = 1'b1; ch_data[31:16] = 16'h00C3; end
      3: freeze = 1'b0;
      4: begin ch_sel = 1'b0; ch_data[15:0] = 16'h0000; dp = 4'b0100; end
      default: ;
    endcase
  endtask

  // Checks one full 64-clock frame starting right after a frame boundary.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpn, input logic exp_tick, input int act);
    logic [6:0] es [4];
    es = '{s0, s1, s2, s3};
    for (int t = 0; t < 64; t++) begin
      int         d;
      int         p;
      bit         on;
      logic [3:0] ea;
      @(posedge clk);
      @(negedge clk);
      d  = t / 16;
      p  = t % 16;
      on = (p >= GUARD) && ((p / 4) <= int'(bright));
      ea = on ? ~(4'b0001 << d) : 4'hF;
      check_val({tag, "_an"},   {28'd0, an},   {28'd0, ea});
      check_val({tag, "_seg"},  {25'd0, seg},  {25'd0, (on ? es[d] : 7'h7F)});
      check_val({tag, "_dpn"},  {31'd0, dp_n}, {31'd0, (on ? dpn[d] : 1'b1)});
      check_val({tag, "_tick"}, {31'd0, frame_tick}, {31'd0, ((t == 63) ? exp_tick : 1'b0)});
      check_val({tag, "_onehot"}, {31'd0, ($countones(~an) <= 1)}, 32'd1);
      if (t == 31) mid_action(act);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    ch_data  = {16'h0005, 16'h1A2F};
    ch_sel   = 1'b0;
    freeze   = 1'b0;
    lz_blank = 1'b0;
    dp       = 4'b0000;
    bright   = 2'd3;

    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    reset_n = 1'b1;
    wait_tick("first_tick", 64);

    check_frame("f1_1A2F",   7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001, 4'hF, 1'b1, 1);
    check_frame("f2_0005",   7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF, 1'b0, 2);
    check_frame("f3_frozen", 7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF, 1'b0, 0);
    check_frame("f4_frozen", 7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF, 1'b0, 0);
    check_frame("f5_release", 7'b0010010, 7'h7F, 7'h7F, 7'h7F, 4'hF, 1'b1, 3);
    check_frame("f6_00C3",   7'b0110000, 7'b1000110, 7'h7F, 7'h7F, 4'hF, 1'b1, 0);
    bright = 2'd0;
    check_frame("f7_bright0", 7'b0110000, 7'b1000110, 7'h7F, 7'h7F, 4'hF, 1'b1, 0);
    bright = 2'd1;
    check_frame("f8_bright1", 7'b0110000, 7'b1000110, 7'h7F, 7'h7F, 4'hF, 1'b1, 4);
    bright = 2'd3;
    check_frame("f9_zero_lz", 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'hF, 1'b1, 0);
    lz_blank = 1'b0;
    check_frame("f10_zero_dp", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1011, 1'b1, 0);

    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    ch_data[15:0] = 16'hBCDE;
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    reset_n = 1'b1;
    wait_tick("tick_after_reset", 64);
    check_frame("f11_BCDE", 7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011, 4'b1011, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
